// File: rtl/axis_dac_playback_pkg.sv
// Shared definitions for the DAC playback path: controller states and the
// stream byte width.
package axis_dac_playback_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/axis_dac_playback_sync_fifo.sv
// Single-clock sample FIFO with show-ahead read data, a synchronous flush and
// an occupancy count. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Qualify requests against occupancy; count never exceeds DEPTH, so its MSB is full.
  always_comb begin
    full    = count[AW];
    empty   = (count == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  // Storage write port.
  // NOTE: the storage array has no reset; only pointers and count need a known value.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axis_dac_playback.sv
// AXI-Stream byte sink that assembles big-endian DAC samples into a FIFO,
// prefills it, then plays one sample per rate tick until play_len samples
// have been output.
module axis_dac_playback
  import axis_dac_playback_pkg::*;
#(
  parameter int DAC_W      = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int PREFILL    = 256
) (
  input  logic             dac_clk,
  input  logic             dac_rst,
  input  logic [31:0]      play_len,
  input  logic [15:0]      rate_div,
  input  logic             play_start,
  output logic             st_busy,
  output logic             play_done,
  output logic             underrun,
  output logic             frame_err,
  input  logic [7:0]       S_AXIS_tdata,
  input  logic             S_AXIS_tkeep,
  input  logic             S_AXIS_tlast,
  input  logic             S_AXIS_tvalid,
  output logic             S_AXIS_tready,
  output logic [DAC_W-1:0] dac_data,
  output logic             dac_valid
);

  localparam int BYTES_PER_SAMPLE = DAC_W / BYTE_W;
  localparam int BC_W  = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [31:0]      play_len_q;
  logic [15:0]      rate_div_q;
  logic [15:0]      rate_cnt;
  logic [31:0]      rx_cnt;
  logic [31:0]      tx_cnt;
  logic [BC_W-1:0]  byte_cnt;
  logic [DAC_W-1:0] asm_q;
  logic             push_pending;

  logic             fifo_flush;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DAC_W-1:0] fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_level;
  logic             byte_acc;
  logic             last_byte;
  logic             tick;

  sync_fifo #(
    .WIDTH (DAC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (dac_clk),
    .rst   (dac_rst),
    .flush (fifo_flush),
    .push  (push_pending),
    .din   (asm_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stream handshake and playback strobes. The pending push is counted in the
  // level so a sample in flight can never overflow the FIFO.
  // NOTE: every combinational output is assigned on all paths, so no latch is inferred.
  always_comb begin
    fifo_level    = fifo_count + CNT_W'(push_pending);
    S_AXIS_tready = ((state == S_FILL) || (state == S_PLAY)) && !fifo_full &&
                    (fifo_level < CNT_W'(FIFO_DEPTH)) && (rx_cnt < play_len_q);
    byte_acc      = S_AXIS_tvalid && S_AXIS_tready && S_AXIS_tkeep;
    last_byte     = (byte_cnt == BC_W'(BYTES_PER_SAMPLE - 1));
    tick          = (state == S_PLAY) && (rate_cnt == 16'd0);
    fifo_pop      = tick && !fifo_empty;
    fifo_flush    = (state == S_IDLE) && play_start;
  end

  // Controller: byte assembly, start/fill/play/done sequencing and registered outputs.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state        <= S_IDLE;
      play_len_q   <= '0;
      rate_div_q   <= '0;
      rate_cnt     <= '0;
      rx_cnt       <= '0;
      tx_cnt       <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      push_pending <= 1'b0;
      st_busy      <= 1'b0;
      play_done    <= 1'b0;
      underrun     <= 1'b0;
      frame_err    <= 1'b0;
      dac_data     <= '0;
      dac_valid    <= 1'b0;
    end else begin
      dac_valid    <= 1'b0;
      play_done    <= 1'b0;
      push_pending <= 1'b0;

      // First byte of a sample lands in the top byte lane, later bytes descend.
      if (byte_acc) begin
        for (int b = 0; b < BYTES_PER_SAMPLE; b++) begin
          if (byte_cnt == BC_W'(b)) asm_q[DAC_W-1-b*BYTE_W -: BYTE_W] <= S_AXIS_tdata;
        end
        if (last_byte) begin
          byte_cnt     <= '0;
          push_pending <= 1'b1;
          rx_cnt       <= rx_cnt + 32'd1;
        end else if (S_AXIS_tlast) begin
          byte_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (play_start) begin
            play_len_q   <= play_len;
            rate_div_q   <= rate_div;
            rate_cnt     <= '0;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            byte_cnt     <= '0;
            push_pending <= 1'b0;
            underrun     <= 1'b0;
            frame_err    <= 1'b0;
            st_busy      <= 1'b1;
            if (play_len == 32'd0) begin
              state     <= S_DONE;
              play_done <= 1'b1;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if ((fifo_count >= CNT_W'(PREFILL)) || (rx_cnt == play_len_q)) begin
            state    <= S_PLAY;
            rate_cnt <= '0;
          end
        end
        S_PLAY: begin
          if (tick) begin
            rate_cnt <= rate_div_q;
            if (!fifo_empty) begin
              dac_data  <= fifo_dout;
              dac_valid <= 1'b1;
              tx_cnt    <= tx_cnt + 32'd1;
              if ((tx_cnt + 32'd1) == play_len_q) begin
                state     <= S_DONE;
                play_done <= 1'b1;
              end
            end else begin
              underrun <= 1'b1;
            end
          end else begin
            rate_cnt <= rate_cnt - 16'd1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          st_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dac_playback.sv
// Self-checking bench for axis_dac_playback: a table of playback runs checked
// against a byte-stream reference model, plus hand-written corner sequences.
module tb_axis_dac_playback;

  localparam int DAC_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int PREFILL    = 2;
  localparam int BPS        = DAC_W / 8;

  logic             dac_clk;
  logic             dac_rst;
  logic [31:0]      play_len;
  logic [15:0]      rate_div;
  logic             play_start;
  logic             st_busy;
  logic             play_done;
  logic             underrun;
  logic             frame_err;
  logic [7:0]       S_AXIS_tdata;
  logic             S_AXIS_tkeep;
  logic             S_AXIS_tlast;
  logic             S_AXIS_tvalid;
  logic             S_AXIS_tready;
  logic [DAC_W-1:0] dac_data;
  logic             dac_valid;

  axis_dac_playback #(
    .DAC_W      (DAC_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PREFILL    (PREFILL)
  ) dut (
    .dac_clk       (dac_clk),
    .dac_rst       (dac_rst),
    .play_len      (play_len),
    .rate_div      (rate_div),
    .play_start    (play_start),
    .st_busy       (st_busy),
    .play_done     (play_done),
    .underrun      (underrun),
    .frame_err     (frame_err),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tkeep  (S_AXIS_tkeep),
    .S_AXIS_tlast  (S_AXIS_tlast),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .dac_data      (dac_data),
    .dac_valid     (dac_valid)
  );

  initial dac_clk = 1'b0;
  always #5 dac_clk = ~dac_clk;

  // One playback run: stimulus knobs plus the flags expected at the end.
  // exp_bp: 1 = source must see back-pressure, 0 = must not, -1 = don't care.
  typedef struct {
    int play_len;
    int rate_div;
    bit fixed;
    int tlast_at;
    int tkeep0_at;
    int stall_at;
    int stall_len;
    int exp_underrun;
    int exp_frame_err;
    int exp_bp;
  } vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] fixed_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  vec_t       vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input int rd, input bit fx, input int tl, input int k0,
                              input int sa, input int sl, input int eu, input int ef, input int eb);
    vec_t v;
    v.play_len = len; v.rate_div = rd; v.fixed = fx; v.tlast_at = tl; v.tkeep0_at = k0;
    v.stall_at = sa; v.stall_len = sl; v.exp_underrun = eu; v.exp_frame_err = ef; v.exp_bp = eb;
    return v;
  endfunction

  task automatic idle_inputs();
    play_start = 1'b0; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = 8'h00;
    S_AXIS_tkeep = 1'b1; S_AXIS_tlast = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".st_busy"},   st_busy,       0);
    check({tag, ".play_done"}, play_done,     0);
    check({tag, ".underrun"},  underrun,      0);
    check({tag, ".frame_err"}, frame_err,     0);
    check({tag, ".tready"},    S_AXIS_tready, 0);
    check({tag, ".dac_data"},  dac_data,      0);
    check({tag, ".dac_valid"}, dac_valid,     0);
  endtask

  // Stream a run through the DUT and compare it with the reference model.
  task automatic run_case(input vec_t v, input string tag);
    logic [7:0]       bq [$];
    bit               lq [$];
    bit               kq [$];
    logic [DAC_W-1:0] exp_s [$];
    logic [DAC_W-1:0] got [$];
    int               gt [$];
    logic [DAC_W-1:0] part;
    int nb, pc, exp_acc, idx, acc, bp, done_cnt, post, cyc, stall_rem, budget, period, bad_gap, g;
    bit hs, long_gap;

    nb = v.play_len * BPS + 2 + ((v.tlast_at >= 0) ? 1 : 0) + ((v.tkeep0_at >= 0) ? 1 : 0);
    for (int i = 0; i < nb; i++) begin
      bq.push_back((v.fixed && i < 8) ? fixed_bytes[i] : 8'($urandom));
      lq.push_back(i == v.tlast_at);
      kq.push_back(i != v.tkeep0_at);
    end

    // Reference: big-endian samples from kept bytes; a packet end mid-sample drops the partial.
    exp_acc = 0; pc = 0; part = '0;
    for (int i = 0; i < nb; i++) begin
      if (exp_s.size() == v.play_len) break;
      exp_acc = i + 1;
      if (!kq[i]) continue;
      part = {part[DAC_W-9:0], bq[i]};
      pc++;
      if (pc == BPS) begin
        exp_s.push_back(part);
        pc = 0;
      end else if (lq[i]) begin
        pc = 0;
      end
    end

    budget = 300 + v.play_len * (v.rate_div + 1) * 3 + v.stall_len;
    @(posedge dac_clk); #1;
    play_len = 32'(v.play_len); rate_div = 16'(v.rate_div); play_start = 1'b1;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = bq[0]; S_AXIS_tlast = lq[0]; S_AXIS_tkeep = kq[0];
    idx = 0; acc = 0; bp = 0; done_cnt = 0; post = 0; cyc = 0; stall_rem = 0;

    while (cyc < budget && post < 4) begin
      @(negedge dac_clk);
      if (dac_valid) begin got.push_back(dac_data); gt.push_back(cyc); end
      if (play_done) done_cnt++;
      if (st_busy && S_AXIS_tvalid && !S_AXIS_tready && idx < exp_acc) bp++;
      hs = S_AXIS_tvalid && S_AXIS_tready;
      if (hs) acc++;
      if (done_cnt > 0) post++;
      cyc++;
      @(posedge dac_clk); #1;
      play_start = 1'b0;
      if (hs) begin
        idx++;
        if (idx == v.stall_at) stall_rem = v.stall_len;
      end
      if (stall_rem > 0) begin
        S_AXIS_tvalid = 1'b0; stall_rem--;
      end else if (idx < nb) begin
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = bq[idx]; S_AXIS_tlast = lq[idx]; S_AXIS_tkeep = kq[idx];
      end else begin
        S_AXIS_tvalid = 1'b0;
      end
    end
    idle_inputs();
    @(negedge dac_clk);

    check({tag, ".play_done_pulses"}, done_cnt, 1);
    check({tag, ".strobes"}, got.size(), exp_s.size());
    for (int i = 0; i < exp_s.size(); i++)
      check($sformatf("%s.sample%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_s[i]));
    check({tag, ".bytes_accepted"}, acc, exp_acc);
    check({tag, ".underrun"}, underrun, v.exp_underrun);
    check({tag, ".frame_err"}, frame_err, v.exp_frame_err);
    check({tag, ".busy_after_done"}, st_busy, 0);
    check({tag, ".tready_after_done"}, S_AXIS_tready, 0);
    if (exp_s.size() > 0) check({tag, ".data_held"}, dac_data, exp_s[exp_s.size()-1]);

    // Ticks are periodic: strobes sit a whole number of periods apart, and any
    // skipped period is exactly a missed (underrun) tick.
    period = v.rate_div + 1; bad_gap = 0; long_gap = 1'b0;
    for (int i = 1; i < gt.size(); i++) begin
      g = gt[i] - gt[i-1];
      if (g < period || (g % period) != 0) bad_gap++;
      if (g > period) long_gap = 1'b1;
    end
    check({tag, ".gap_period_multiple"}, bad_gap, 0);
    check({tag, ".underrun_vs_gaps"}, underrun, long_gap);
    if (v.exp_bp >= 0) check({tag, ".backpressure"}, (bp > 0) ? 1 : 0, v.exp_bp);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, rdy_cnt, strobes, cyc;
    bit first_done;

    // len, rd, fixed, tlast_at, tkeep0_at, stall_at, stall_len, exp_ur, exp_fe, exp_bp
    vecs[0] = mk(4,  3,  1, -1, -1, -1, 0,  0, 0, -1);
    vecs[1] = mk(8,  0,  0, -1, -1,  6, 20, 1, 0, -1);
    vecs[2] = mk(2,  3,  0,  0, -1, -1, 0,  0, 1, -1);
    vecs[3] = mk(10, 15, 0, -1, -1, -1, 0,  0, 0, 1);
    vecs[4] = mk(3,  2,  0, -1,  2, -1, 0,  0, 0, -1);
    for (int i = 5; i < 11; i++)
      vecs[i] = mk(1 + int'($urandom_range(0, 9)), int'($urandom_range(3, 6)), 0, -1,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, -1, 0, 0, 0, -1);

    idle_inputs();
    play_len = '0; rate_div = '0;
    dac_rst = 1'b1;
    repeat (3) @(posedge dac_clk);
    @(negedge dac_clk);
    check_all_zero("reset");
    @(posedge dac_clk); #1;
    dac_rst = 1'b0;

    for (int i = 0; i < 11; i++) run_case(vecs[i], $sformatf("vec%0d", i));

    // Zero-length run: straight to DONE, one busy cycle, stream never ready.
    @(posedge dac_clk); #1;
    play_len = 32'd0; rate_div = 16'd5; play_start = 1'b1;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 8'hA5;
    @(posedge dac_clk); #1;
    play_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; rdy_cnt = 0; first_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge dac_clk);
      if (c == 0) first_done = play_done;
      busy_cnt += st_busy ? 1 : 0;
      done_cnt += play_done ? 1 : 0;
      rdy_cnt  += S_AXIS_tready ? 1 : 0;
    end
    idle_inputs();
    check("len0.done_next_cycle", first_done, 1);
    check("len0.done_pulses", done_cnt, 1);
    check("len0.busy_cycles", busy_cnt, 1);
    check("len0.tready_cycles", rdy_cnt, 0);

    // Reset in the middle of playback, then a fresh short run.
    @(posedge dac_clk); #1;
    play_len = 32'd6; rate_div = 16'd7; play_start = 1'b1;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 8'($urandom);
    strobes = 0; cyc = 0;
    while (strobes < 2 && cyc < 400) begin
      @(negedge dac_clk);
      if (dac_valid) strobes++;
      cyc++;
      if (S_AXIS_tvalid && S_AXIS_tready) begin
        @(posedge dac_clk); #1;
        S_AXIS_tdata = 8'($urandom);
      end else begin
        @(posedge dac_clk); #1;
      end
      play_start = 1'b0;
    end
    check("midreset.reached_play", strobes, 2);
    dac_rst = 1'b1;
    idle_inputs();
    @(posedge dac_clk); #1;
    @(negedge dac_clk);
    check_all_zero("midreset");
    @(posedge dac_clk); #1;
    dac_rst = 1'b0;
    run_case(mk(2, 3, 0, -1, -1, -1, 0, 0, 0, -1), "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
